// File: rtl/program_loader.sv
// program_loader: receives a little-endian byte stream, assembles halfword
// instructions and writes them into CPU program memory, holding the CPU in
// reset until a load has completed successfully.
//
// Ports:
//   clk_i, reset_i           clock, asynchronous active-high reset
//   load_start_i             one-cycle pulse that starts a load (honoured in IDLE only)
//   load_len_i, base_addr_i  halfword count and byte base address, sampled on start
//   byte_valid_i/byte_data_i stream byte offered; byte_ready_o accepts it
//   program_mem_write_en_o   one-cycle program-memory write strobe
//   instruction_o            assembled halfword, held between writes
//   instruction_addr_o       byte address of the write, held between writes
//   cpu_reset_o              holds the CPU pipeline in reset
//   busy_o, done_o, error_o  status; done/error are sticky until the next accepted start
module program_loader #(
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    parameter int unsigned RELEASE_CYCLES = 4,
    parameter int unsigned WORD           = 32,
    localparam int unsigned HALF_WORD     = 16
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    input  logic                 load_start_i,
    input  logic [15:0]          load_len_i,
    input  logic [WORD-1:0]      base_addr_i,
    input  logic                 byte_valid_i,
    input  logic [7:0]           byte_data_i,
    output logic                 byte_ready_o,
    output logic                 program_mem_write_en_o,
    output logic [HALF_WORD-1:0] instruction_o,
    output logic [WORD-1:0]      instruction_addr_o,
    output logic                 cpu_reset_o,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 error_o
);

    localparam int unsigned LEN_W  = 16;
    localparam int unsigned IDLE_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned REL_W  = $clog2(RELEASE_CYCLES + 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOW     = 3'd1,
        HIGH    = 3'd2,
        WRITE   = 3'd3,
        RELEASE = 3'd4
    } state_t;

    state_t               state_q, state_d;
    logic [LEN_W-1:0]     len_q, len_d;
    logic [LEN_W-1:0]     idx_q, idx_d;
    logic [WORD-1:0]      base_q, base_d;
    logic [7:0]           lo_q, lo_d;
    logic [IDLE_W-1:0]    idle_q, idle_d;
    logic [REL_W-1:0]     rel_q, rel_d;
    logic [HALF_WORD-1:0] instr_q, instr_d;
    logic [WORD-1:0]      addr_q, addr_d;
    logic                 cpu_rst_q, cpu_rst_d;
    logic                 done_q, done_d;
    logic                 err_q, err_d;

    logic ready_c;
    logic xfer_c;
    logic idle_expired_c;

    // State and datapath registers
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q   <= IDLE;
            len_q     <= '0;
            idx_q     <= '0;
            base_q    <= '0;
            lo_q      <= '0;
            idle_q    <= '0;
            rel_q     <= '0;
            instr_q   <= '0;
            addr_q    <= '0;
            cpu_rst_q <= 1'b1;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            len_q     <= len_d;
            idx_q     <= idx_d;
            base_q    <= base_d;
            lo_q      <= lo_d;
            idle_q    <= idle_d;
            rel_q     <= rel_d;
            instr_q   <= instr_d;
            addr_q    <= addr_d;
            cpu_rst_q <= cpu_rst_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    assign ready_c        = (state_q == LOW) || (state_q == HIGH);
    assign xfer_c         = byte_valid_i && ready_c;
    assign idle_expired_c = (idle_q == IDLE_W'(TIMEOUT_CYCLES - 1));

    // Next-state and datapath update
    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        idx_d     = idx_q;
        base_d    = base_q;
        lo_d      = lo_q;
        idle_d    = idle_q;
        rel_d     = rel_q;
        instr_d   = instr_q;
        addr_d    = addr_q;
        cpu_rst_d = cpu_rst_q;
        done_d    = done_q;
        err_d     = err_q;

        case (state_q)
            IDLE: begin
                if (load_start_i) begin
                    done_d    = 1'b0;
                    err_d     = 1'b0;
                    cpu_rst_d = 1'b1;
                    len_d     = load_len_i;
                    base_d    = base_addr_i;
                    idx_d     = '0;
                    idle_d    = '0;
                    rel_d     = '0;
                    state_d   = (load_len_i == '0) ? RELEASE : LOW;
                end
            end
            LOW, HIGH: begin
                if (xfer_c) begin
                    idle_d = '0;
                    if (state_q == LOW) begin
                        lo_d    = byte_data_i;
                        state_d = HIGH;
                    end else begin
                        instr_d = {byte_data_i, lo_q};
                        // Byte address wraps modulo 2^WORD by construction
                        addr_d  = base_q + (WORD'(idx_q) << 1);
                        state_d = WRITE;
                    end
                end else if (idle_expired_c) begin
                    // Abort: CPU stays in reset, partial data is dropped
                    idle_d  = '0;
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    idle_d = idle_q + IDLE_W'(1);
                end
            end
            WRITE: begin
                idx_d   = idx_q + LEN_W'(1);
                state_d = ((idx_q + LEN_W'(1)) == len_q) ? RELEASE : LOW;
            end
            RELEASE: begin
                if (rel_q == REL_W'(RELEASE_CYCLES - 1)) begin
                    rel_d     = '0;
                    cpu_rst_d = 1'b0;
                    done_d    = 1'b1;
                    state_d   = IDLE;
                end else begin
                    rel_d = rel_q + REL_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Strobes and status decode straight from the state register
    assign byte_ready_o           = ready_c;
    assign program_mem_write_en_o = (state_q == WRITE);
    assign busy_o                 = (state_q != IDLE);
    assign instruction_o          = instr_q;
    assign instruction_addr_o     = addr_q;
    assign cpu_reset_o            = cpu_rst_q;
    assign done_o                 = done_q;
    assign error_o                = err_q;

endmodule

// File: tb/tb_program_loader.sv
// tb_program_loader: table-driven and randomized checking of program_loader
// against an arithmetic model of the expected write sequence.
module tb_program_loader;

    localparam int unsigned TO    = 16;
    localparam int unsigned RC    = 4;
    localparam int unsigned WORD  = 32;
    localparam int          LIMIT = 2000;

    logic            clk_i = 1'b0;
    logic            reset_i;
    logic            load_start_i;
    logic [15:0]     load_len_i;
    logic [WORD-1:0] base_addr_i;
    logic            byte_valid_i;
    logic [7:0]      byte_data_i;
    logic            byte_ready_o;
    logic            program_mem_write_en_o;
    logic [15:0]     instruction_o;
    logic [WORD-1:0] instruction_addr_o;
    logic            cpu_reset_o;
    logic            busy_o;
    logic            done_o;
    logic            error_o;

    program_loader #(
        .TIMEOUT_CYCLES(TO),
        .RELEASE_CYCLES(RC),
        .WORD          (WORD)
    ) dut (
        .clk_i                 (clk_i),
        .reset_i               (reset_i),
        .load_start_i          (load_start_i),
        .load_len_i            (load_len_i),
        .base_addr_i           (base_addr_i),
        .byte_valid_i          (byte_valid_i),
        .byte_data_i           (byte_data_i),
        .byte_ready_o          (byte_ready_o),
        .program_mem_write_en_o(program_mem_write_en_o),
        .instruction_o         (instruction_o),
        .instruction_addr_o    (instruction_addr_o),
        .cpu_reset_o           (cpu_reset_o),
        .busy_o                (busy_o),
        .done_o                (done_o),
        .error_o               (error_o)
    );

    always #5 clk_i = ~clk_i;

    // mode: 0 valid always, 1 valid toggles, 2 random valid, 3 gap of TO-1 before each byte
    typedef struct {
        logic [31:0] base;
        logic [15:0] len;
        int          mode;
        int          max_bytes;
        int          spur_cyc;
        bit          fixed;
        int          exp_writes;
        bit          exp_done;
        bit          exp_error;
        bit          exp_cpu_rst;
    } vec_t;

    int          n_checks = 0;
    int          n_pass   = 0;
    int          cyc      = 0;
    int          ready_viol = 0;
    logic [7:0]  fixed_pat [6];
    logic [7:0]  stim [$];
    logic [31:0] wr_addr [$];
    logic [15:0] wr_data [$];
    int          wr_cyc [$];
    int          base_cyc, fin_c, last_x_c;
    logic        done_at1, err_at1, cpu_at1;
    bit          finished;
    vec_t        vecs [7];

    always @(posedge clk_i) cyc <= cyc + 1;

    // Write-port monitor and handshake sanity
    always @(negedge clk_i) begin
        if (program_mem_write_en_o === 1'b1) begin
            wr_addr.push_back(instruction_addr_o);
            wr_data.push_back(instruction_o);
            wr_cyc.push_back(cyc);
        end
        if (byte_ready_o && (program_mem_write_en_o || !busy_o))
            ready_viol <= ready_viol + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        n_checks++;
        if (act !== want)
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, want);
        else
            n_pass++;
    endtask

    task automatic fill_stim(input vec_t v);
        stim.delete();
        for (int i = 0; i < 2 * int'(v.len); i++)
            stim.push_back(v.fixed ? fixed_pat[i % 6] : 8'($urandom));
    endtask

    // Drive one load from the start pulse until busy_o drops
    task automatic run_load(input vec_t v);
        int ptr = 0;
        int c = 0;
        int gap;
        int lowrun = 0;
        int nsend;
        bit bv;
        bit xfer;
        nsend = (2 * int'(v.len) < v.max_bytes) ? 2 * int'(v.len) : v.max_bytes;
        gap = (v.mode == 3) ? int'(TO) - 1 : 0;
        wr_addr.delete();
        wr_data.delete();
        wr_cyc.delete();
        finished = 0;
        fin_c = -1;
        last_x_c = -1;
        @(posedge clk_i); #1;
        base_cyc = cyc;
        while (!finished && c < LIMIT) begin
            load_start_i = (c == 0) || (c == v.spur_cyc);
            if (c == 0) begin
                load_len_i  = v.len;
                base_addr_i = v.base;
            end else if (c == v.spur_cyc) begin
                load_len_i  = v.len + 16'd7;
                base_addr_i = ~v.base;
            end
            bv = 0;
            if (ptr < nsend) begin
                case (v.mode)
                    0: bv = 1;
                    1: bv = (c % 2 == 0);
                    2: bv = ($urandom_range(0, 2) != 0) || (lowrun >= 3);
                    default: if (gap > 0) gap--; else bv = 1;
                endcase
            end
            lowrun = bv ? 0 : lowrun + 1;
            byte_valid_i = bv;
            byte_data_i  = (ptr < nsend) ? stim[ptr] : 8'($urandom);
            @(negedge clk_i);
            if (c == 1) begin
                done_at1 = done_o;
                err_at1  = error_o;
                cpu_at1  = cpu_reset_o;
            end
            if (c > 0 && !busy_o) begin
                finished = 1;
                fin_c = c;
            end
            xfer = byte_valid_i && byte_ready_o;
            @(posedge clk_i); #1;
            if (xfer) begin
                ptr++;
                last_x_c = c;
                gap = (v.mode == 3) ? int'(TO) - 1 : 0;
            end
            c++;
        end
        load_start_i = 0;
        byte_valid_i = 0;
        if (!finished) check("load_finished", 32'd0, 32'd1);
    endtask

    // Compare a finished load against the expected write sequence and status
    task automatic check_load(input vec_t v, input string tag);
        int rel;
        int n;
        check({tag, "_writes"}, 32'(wr_data.size()), 32'(v.exp_writes));
        for (int k = 0; k < v.exp_writes && k < wr_data.size(); k++) begin
            check({tag, "_addr"}, wr_addr[k], v.base + 32'(2 * k));
            check({tag, "_data"}, 32'(wr_data[k]), 32'({stim[2*k+1], stim[2*k]}));
        end
        check({tag, "_done"},    32'(done_o),      32'(v.exp_done));
        check({tag, "_error"},   32'(error_o),     32'(v.exp_error));
        check({tag, "_cpu_rst"}, 32'(cpu_reset_o), 32'(v.exp_cpu_rst));
        check({tag, "_busy"},    32'(busy_o),      32'd0);
        check({tag, "_start_clr"}, 32'({done_at1, err_at1, cpu_at1}), 32'b001);
        if (v.exp_error) begin
            check({tag, "_timeout_lat"}, 32'(fin_c - last_x_c), 32'(TO + 1));
        end else begin
            rel = (wr_cyc.size() > 0) ? wr_cyc[$] - base_cyc : 0;
            check({tag, "_release_lat"}, 32'(fin_c - rel), 32'(RC + 1));
        end
        n = v.exp_writes;
        if (n > 0 && wr_data.size() > 0)
            check({tag, "_instr_hold"}, 32'(instruction_o), 32'({stim[2*n-1], stim[2*n-2]}));
    endtask

    initial begin
        vec_t r;
        fixed_pat = '{8'h34, 8'h12, 8'h78, 8'h56, 8'hBC, 8'h9A};
        //            base           len  mode max  spur fixed wr done err cpu
        vecs[0] = '{32'h0000_0100, 16'd3, 0, 1000, -1, 1'b1, 3, 1'b1, 1'b0, 1'b0};
        vecs[1] = '{32'h0000_0100, 16'd2, 1, 1000, -1, 1'b1, 2, 1'b1, 1'b0, 1'b0};
        vecs[2] = '{32'h0000_0400, 16'd2, 0, 3,    -1, 1'b0, 1, 1'b0, 1'b1, 1'b1};
        vecs[3] = '{32'h0000_0800, 16'd0, 0, 1000, -1, 1'b0, 0, 1'b1, 1'b0, 1'b0};
        vecs[4] = '{32'hFFFF_FFFE, 16'd2, 2, 1000, -1, 1'b0, 2, 1'b1, 1'b0, 1'b0};
        vecs[5] = '{32'h0000_0010, 16'd2, 3, 1000, -1, 1'b0, 2, 1'b1, 1'b0, 1'b0};
        vecs[6] = '{32'h0000_0200, 16'd2, 0, 1000,  2, 1'b1, 2, 1'b1, 1'b0, 1'b0};

        reset_i = 1'b1;
        load_start_i = 0;
        load_len_i = '0;
        base_addr_i = '0;
        byte_valid_i = 0;
        byte_data_i = '0;
        #1;
        check("rst_outputs", 32'({byte_ready_o, program_mem_write_en_o, cpu_reset_o,
                                  busy_o, done_o, error_o}), 32'b001000);
        check("rst_instr", 32'(instruction_o), 32'd0);
        check("rst_addr",  instruction_addr_o, 32'd0);
        repeat (3) @(posedge clk_i);
        #1 reset_i = 1'b0;

        for (int i = 0; i < 7; i++) begin
            fill_stim(vecs[i]);
            run_load(vecs[i]);
            check_load(vecs[i], $sformatf("vec%0d", i));
            if (i == 0 && wr_data.size() == 3) begin
                check("nom_w0", 32'(wr_data[0]), 32'h1234);
                check("nom_w1", 32'(wr_data[1]), 32'h5678);
                check("nom_w2", 32'(wr_data[2]), 32'h9ABC);
                check("nom_a2", wr_addr[2], 32'h0000_0104);
            end
        end

        for (int i = 0; i < 15; i++) begin
            r = '{$urandom, 16'($urandom_range(1, 5)), 2, 1000, -1, 1'b0, 0, 1'b1, 1'b0, 1'b0};
            r.exp_writes = int'(r.len);
            fill_stim(r);
            run_load(r);
            check_load(r, $sformatf("rnd%0d", i));
        end

        // Asynchronous reset between the LOW and HIGH bytes
        @(posedge clk_i); #1;
        load_start_i = 1; load_len_i = 16'd2; base_addr_i = 32'h3000;
        byte_valid_i = 1; byte_data_i = 8'hAA;
        @(posedge clk_i); #1;
        load_start_i = 0;
        @(posedge clk_i); #1;
        byte_valid_i = 0;
        check("mid_busy_high", 32'({busy_o, byte_ready_o}), 32'b11);
        #2 reset_i = 1'b1;
        #1;
        check("mid_rst_outputs", 32'({byte_ready_o, program_mem_write_en_o, cpu_reset_o,
                                      busy_o, done_o, error_o}), 32'b001000);
        check("mid_rst_instr", 32'(instruction_o), 32'd0);
        check("mid_rst_addr",  instruction_addr_o, 32'd0);
        @(negedge clk_i);
        reset_i = 1'b0;
        r = '{32'h0000_5000, 16'd1, 0, 1000, -1, 1'b0, 1, 1'b1, 1'b0, 1'b0};
        fill_stim(r);
        run_load(r);
        check_load(r, "post_rst");

        check("ready_only_low_high", 32'(ready_viol), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/program_loader.md
PROGRAM_LOADER -- requirements
Module: program_loader

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 1024: max idle cycles between stream bytes before abort.
REQ-002 SHALL have parameter RELEASE_CYCLES, default 4: cycles cpu_reset_o stays high after the last write.
REQ-003 SHALL have one clock and an asynchronous, active-high reset: clk_i input 1 (rising edge); reset_i input 1 (asynchronous, active-high).
REQ-004 SHALL have load_start_i input 1: single-cycle pulse that begins a load.
REQ-005 SHALL have load_len_i input 16: number of halfword instructions to load, sampled on load_start_i.
REQ-006 SHALL have base_addr_i input WORD: byte address of the first instruction, sampled on load_start_i.
REQ-007 SHALL have byte_valid_i input 1 and byte_data_i input 8: stream byte offered.
REQ-008 SHALL have byte_ready_o output 1: loader accepts the byte this cycle.
REQ-009 SHALL have program_mem_write_en_o output 1, instruction_o output HALF_WORD, and instruction_addr_o output WORD: drive the CPU program-memory write port.
REQ-010 SHALL have cpu_reset_o output 1: holds the CPU pipeline in reset.
REQ-011 SHALL have busy_o, done_o and error_o outputs, 1 bit each: status.

Function
REQ-012 SHALL implement states IDLE, LOW, HIGH, WRITE, RELEASE.
REQ-013 In IDLE, load_start_i with load_len_i>0 SHALL latch length and base address, clear the counters, and go to LOW next cycle.
REQ-014 In IDLE, load_start_i with load_len_i==0 SHALL go directly to RELEASE, with no write.
REQ-015 byte_ready_o SHALL be 1 only in LOW and HIGH; a byte transfers when byte_valid_i && byte_ready_o.
REQ-016 Bytes SHALL be little-endian: the LOW transfer gives instruction bits [7:0], the HIGH transfer gives bits [15:8]; each transfer advances the state.
REQ-017 In WRITE, program_mem_write_en_o SHALL be 1 for exactly one cycle, with instruction_o = assembled halfword and instruction_addr_o = base + 2*index.
REQ-018 After WRITE, the index SHALL increment; if index+1 == length go to RELEASE, otherwise go to LOW.
REQ-019 Address arithmetic SHALL be WORD-bit modulo 2^WORD; wrap-around is permitted and not flagged.
REQ-020 Outside WRITE, program_mem_write_en_o SHALL be 0, and instruction_o and instruction_addr_o SHALL hold their last values.
REQ-021 The idle counter SHALL count cycles in LOW/HIGH without a transfer and reset on each transfer.
REQ-022 When the idle counter reaches TIMEOUT_CYCLES, the loader SHALL set error_o, return to IDLE and keep cpu_reset_o=1.
REQ-023 RELEASE SHALL last RELEASE_CYCLES cycles, then go to IDLE, set done_o=1 and set cpu_reset_o=0.
REQ-024 busy_o SHALL be 1 in every state except IDLE.
REQ-025 load_start_i while busy_o=1 SHALL be ignored.
REQ-026 cpu_reset_o SHALL be 1 from reset until the first successful RELEASE completes.
REQ-027 A new load_start_i accepted after done_o=1 SHALL reassert cpu_reset_o=1 and clear done_o and error_o in the same edge.
REQ-028 done_o and error_o SHALL be sticky until the next accepted load_start_i or reset.
REQ-029 A byte offered in the same cycle as the LOW entry edge SHALL NOT be consumed; consumption begins the cycle the state is LOW.

Reset
REQ-030 reset_i SHALL act asynchronously, at any time including mid-load, forcing IDLE and discarding any partial halfword.
REQ-031 While reset_i is asserted, outputs SHALL be byte_ready_o=0, program_mem_write_en_o=0, instruction_o=0, instruction_addr_o=0, cpu_reset_o=1, busy_o=0, done_o=0, error_o=0, and all counters 0.

Verification
REQ-032 Nominal load: base=0x100, len=3, bytes 34 12 78 56 BC 9A with valid always high -> writes 0x1234@0x100, 0x5678@0x102, 0x9ABC@0x104; each write 1 cycle; done_o=1; cpu_reset_o falls RELEASE_CYCLES cycles after the last write.
REQ-033 Backpressure: byte_valid_i toggling 1/0 each cycle with len=2 -> identical data and addresses to the gapless case, with no duplicated or dropped bytes.
REQ-034 Timeout: len=2, 3 bytes sent then stream stops -> error_o=1 after TIMEOUT_CYCLES idle cycles; exactly 1 write occurred; cpu_reset_o stays 1; busy_o=0.
REQ-035 Zero length: load_start_i with len=0 -> no write; done_o=1 and cpu_reset_o=0 after RELEASE_CYCLES.
REQ-036 Reset mid-load: reset_i pulse between the LOW and HIGH bytes -> all outputs at reset values immediately (asynchronously); a subsequent len=1 load writes only the new halfword at base.
REQ-037 Ignored start: load_start_i pulse during HIGH with different len/base -> the original load completes unchanged.
